module_fetch_unit: RTL

Instruction-fetch and program-load front end sitting directly upstream of module_instruction_memory; it drives that memory's addr/prog/code inputs and consumes its registered instruction output. In PROG mode it streams words from an external loader into instruction memory sequentially. In RUN mode it maintains the word-addressed PC, issues reads and presents instruction+PC to decode with stall and branch-redirect support (MIPS delay-slot semantics).

---
 rtl/module_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/module_fetch_unit.sv
// Instruction-fetch / program-load front end for module_instruction_memory.
// Optional PROG_CHECKSUM_EN adds load_checksum (XOR of words accepted since load_start).
module module_fetch_unit #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MEMORY       = 1024,
  parameter int RESET_PC     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic [WORD_SIZE-1:0]    load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  input  logic                    run_start,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  output logic                    imem_prog,
  output logic [WORD_SIZE-1:0]    imem_code,
  input  logic [WORD_SIZE-1:0]    imem_instruction,
  output logic                    fetch_valid,
  output logic [WORD_SIZE-1:0]    fetch_instr,
  output logic [ADDRESS_BITS-1:0] fetch_pc,
`ifdef PROG_CHECKSUM_EN
  output logic [WORD_SIZE-1:0]    load_checksum,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROG = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDRESS_BITS-1:0] MEM_WORDS = ADDRESS_BITS'(MEMORY);
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(MEMORY - 1);
  localparam logic [ADDRESS_BITS-1:0] START_PC  = ADDRESS_BITS'(RESET_PC);

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic [ADDRESS_BITS-1:0] load_cnt_q, load_cnt_d;
`ifdef PROG_CHECKSUM_EN
  logic [WORD_SIZE-1:0]    checksum_q, checksum_d;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    load_cnt_d    = load_cnt_q;
`ifdef PROG_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif
    load_ready    = 1'b0;
    imem_prog     = 1'b0;
    imem_addr     = '0;
    imem_code     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_PROG;
          load_cnt_d = '0;
`ifdef PROG_CHECKSUM_EN
          checksum_d = '0;
`endif
        end else if (run_start) begin
          state_d       = ST_RUN;
          pc_d          = START_PC;
          fetch_valid_d = 1'b0;
        end
      end

      ST_PROG: begin
        load_ready = 1'b1;
        imem_prog  = load_valid;
        imem_addr  = load_cnt_q;
        imem_code  = load_data;
        if (load_valid) begin
`ifdef PROG_CHECKSUM_EN
          checksum_d = checksum_q ^ load_data;
`endif
          if (load_last || (load_cnt_q == LAST_ADDR)) begin
            state_d    = ST_IDLE;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + ADDRESS_BITS'(1);
          end
        end
      end

      ST_RUN: begin
        // Redirect beats stall; a stalled valid instruction is re-read to hold it steady.
        if (redirect) begin
          imem_addr = redirect_pc % MEM_WORDS;
        end else if (stall && fetch_valid_q) begin
          imem_addr = fetch_pc_q;
        end else begin
          imem_addr = pc_q;
        end
        fetch_pc_d    = imem_addr;
        fetch_valid_d = 1'b1;
        pc_d          = (imem_addr == LAST_ADDR) ? '0 : imem_addr + ADDRESS_BITS'(1);
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= START_PC;
      fetch_pc_q    <= START_PC;
      fetch_valid_q <= 1'b0;
      load_cnt_q    <= '0;
`ifdef PROG_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      load_cnt_q    <= load_cnt_d;
`ifdef PROG_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_instr = imem_instruction;
  assign busy        = (state_q != ST_IDLE);
`ifdef PROG_CHECKSUM_EN
  assign load_checksum = checksum_q;
`endif

endmodule
